// File: rtl/rvscc_pkg.sv
// Shared types and defaults for the memory-port arbiter.
package rvscc_pkg;

  localparam int unsigned DefAddrWidth = 32;
  localparam int unsigned DefDataWidth = 32;

  typedef enum logic [1:0] {
    StIdle       = 2'd0,
    StServeFetch = 2'd1,
    StServeData  = 2'd2
  } arb_state_e;

  // Counter width able to hold 0..max_streak, never narrower than one bit.
  function automatic int unsigned streak_width(input int unsigned max_streak);
    return (max_streak > 0) ? $clog2(max_streak + 1) : 1;
  endfunction

endpackage

// File: rtl/arb_streak_counter.sv
// Counts data grants issued while a fetch waits; saturates so fetch can win.
module arb_streak_counter
  import rvscc_pkg::*;
#(
  parameter int unsigned MAX_STREAK = 4,
  localparam int unsigned CntW = streak_width(MAX_STREAK)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic idle_i,
  input  logic fetch_pending_i,
  input  logic data_grant_i,
  input  logic fetch_grant_i,
  output logic saturated_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign saturated_o = (cnt_q == CntW'(MAX_STREAK));

  always_comb begin
    cnt_d = cnt_q;
    if (fetch_grant_i || (idle_i && !fetch_pending_i)) begin
      cnt_d = '0;
    end else if (data_grant_i && fetch_pending_i && !saturated_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data-stage requests onto one single-ported memory.
module mem_port_arbiter
  import rvscc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = DefAddrWidth,
  parameter int unsigned DATA_WIDTH      = DefDataWidth,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_valid,
  output logic                  if_stall,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_valid,
  output logic                  dm_stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  arb_state_e            state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic                  if_valid_q, if_valid_d;
  logic                  dm_valid_q, dm_valid_d;
  logic                  flushed_q, flushed_d;

  logic is_idle, if_req_eff, grant_data, grant_fetch, streak_sat;

  // A flush in the grant cycle hides the fetch request from arbitration.
  assign is_idle     = (state_q == StIdle);
  assign if_req_eff  = if_req & ~if_flush;
  assign grant_data  = is_idle & dm_req & (~if_req_eff | ~streak_sat);
  assign grant_fetch = is_idle & if_req_eff & ~grant_data;

  arb_streak_counter #(
    .MAX_STREAK(MAX_DATA_STREAK)
  ) u_streak (
    .clk_i          (clk),
    .rst_i          (rst),
    .idle_i         (is_idle),
    .fetch_pending_i(if_req_eff),
    .data_grant_i   (grant_data),
    .fetch_grant_i  (grant_fetch),
    .saturated_o    (streak_sat)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    flushed_d   = flushed_q;
    unique case (state_q)
      StIdle: begin
        flushed_d = 1'b0;
        if (grant_data) begin
          state_d     = StServeData;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
        end else if (grant_fetch) begin
          state_d     = StServeFetch;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
        end
      end
      StServeFetch: begin
        if (if_flush) flushed_d = 1'b1;
        if (mem_ready) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          // A flushed fetch still drains the memory but is never delivered.
          if (!flushed_q && !if_flush) begin
            if_rdata_d = mem_rdata;
            if_valid_d = 1'b1;
          end
        end
      end
      StServeData: begin
        if (mem_ready) begin
          state_d    = StIdle;
          mem_req_d  = 1'b0;
          dm_rdata_d = mem_rdata;
          dm_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      flushed_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
      flushed_q   <= flushed_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_valid  = if_valid_q;
  assign dm_valid  = dm_valid_q;
  assign if_stall  = if_req & ~if_valid_q;
  assign dm_stall  = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory responder, grant monitor, scenario tasks.
module tb_mem_port_arbiter;
  import rvscc_pkg::*;

  localparam int MaxS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, if_flush = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        if_valid, if_stall, dm_valid, dm_stall, mem_req, mem_we, mem_ready;
  logic        resp_ready = 1'b0, inj_ready = 1'b0;

  assign mem_ready = resp_ready | inj_ready;

  mem_port_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_DATA_STREAK(MaxS)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        grant_q[$];
  int          n_checks = 0, n_fail = 0;
  int          if_pulses = 0, dm_pulses = 0, done_cnt = 0;
  int          ready_delay = 0, wait_cnt = 0;
  bit          rand_delay = 1'b0;
  logic        mem_req_prev = 1'b0;
  logic [31:0] mem_store[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];

  function automatic logic [31:0] def_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory: completes after ready_delay cycles of mem_req; writes return ~wdata.
  always @(negedge clk) begin
    resp_ready = 1'b0;
    if (rst || !mem_req) begin
      wait_cnt = 0;
    end else if (wait_cnt >= ready_delay) begin
      resp_ready = 1'b1;
      wait_cnt   = 0;
      if (mem_we) begin
        mem_store[mem_addr] = mem_wdata;
        mem_rdata = ~mem_wdata;
      end else begin
        mem_rdata = mem_store.exists(mem_addr) ? mem_store[mem_addr] : def_word(mem_addr);
      end
      done_cnt++;
      if (rand_delay) ready_delay = $urandom_range(0, 3);
    end else begin
      wait_cnt++;
    end
  end

  // Grant log, valid pulse counts and operand stability while mem_req is high.
  always @(negedge clk) begin
    if (if_valid) if_pulses++;
    if (dm_valid) dm_pulses++;
    if (mem_req && !mem_req_prev) begin
      grant_q.push_back('{we: mem_we, addr: mem_addr, wdata: mem_wdata});
    end else if (mem_req && grant_q.size() > 0) begin
      n_checks++;
      if ({mem_we, mem_addr, mem_wdata} !== {grant_q[$].we, grant_q[$].addr, grant_q[$].wdata})
      begin
        n_fail++;
        $display("FAIL mem_stable: got we=%0b addr=%h wdata=%h want we=%0b addr=%h wdata=%h",
                 mem_we, mem_addr, mem_wdata, grant_q[$].we, grant_q[$].addr, grant_q[$].wdata);
      end
    end
    mem_req_prev = mem_req;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    int lat;
    rst = 1'b1;
    step();
    step();
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_checks++;
    if ({mem_we, mem_addr, mem_wdata} !== 65'd0) begin
      n_fail++; $display("FAIL reset_mem_bus: got we=%b addr=%h wdata=%h want 0", mem_we, mem_addr, mem_wdata);
    end
    n_checks++;
    if ({if_valid, dm_valid, if_stall, dm_stall} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {if_valid, dm_valid, if_stall, dm_stall});
    end
    n_checks++;
    if ({if_rdata, dm_rdata} !== 64'd0) begin
      n_fail++; $display("FAIL reset_rdata: got if=%h dm=%h want 0", if_rdata, dm_rdata);
    end
    n_checks++; if (dut.u_streak.cnt_q !== '0) begin n_fail++; $display("FAIL reset_streak: got %0d want 0", dut.u_streak.cnt_q); end
    // First grant on the first rising edge after release.
    ready_delay = 0;
    rst = 1'b0; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40; dm_wdata = 32'h1234_5678;
    step();
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL first_grant: got mem_req=%b want 1", mem_req); end
    lat = 1;
    while (!dm_valid && lat < 20) begin step(); lat++; end
    dm_req = 1'b0;
    n_checks++; if (dm_rdata !== def_word(32'h40)) begin n_fail++; $display("FAIL first_rdata: got %h want %h", dm_rdata, def_word(32'h40)); end
    step();
  endtask

  task automatic test_fetch_alone();
    int lat, p0;
    p0 = if_pulses;
    ready_delay = 1;
    if_req = 1'b1; if_addr = 32'h100;
    step();
    lat = 1;
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL fetch_issue: got req=%b addr=%h we=%b want 1 00000100 0", mem_req, mem_addr, mem_we);
    end
    n_checks++; if (if_stall !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_wait: got %b want 1", if_stall); end
    while (!if_valid && lat < 20) begin step(); lat++; end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL fetch_latency: got %0d want 3", lat); end
    n_checks++; if (if_rdata !== def_word(32'h100)) begin n_fail++; $display("FAIL fetch_rdata: got %h want %h", if_rdata, def_word(32'h100)); end
    n_checks++; if (if_stall !== 1'b0) begin n_fail++; $display("FAIL fetch_stall_done: got %b want 0", if_stall); end
    if_req = 1'b0;
    repeat (3) step();
    n_checks++; if (if_pulses - p0 !== 1) begin n_fail++; $display("FAIL fetch_pulses: got %0d want 1", if_pulses - p0); end
  endtask

  task automatic test_min_latency();
    int lat;
    ready_delay = 0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80; dm_wdata = 32'h0;
    step();
    lat = 1;
    while (!dm_valid && lat < 20) begin step(); lat++; end
    dm_req = 1'b0;
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL min_latency: got %0d want 2", lat); end
    n_checks++; if (dm_rdata !== def_word(32'h80)) begin n_fail++; $display("FAIL min_rdata: got %h want %h", dm_rdata, def_word(32'h80)); end
    step();
  endtask

  task automatic test_priority();
    int cyc, dm_at, if_at;
    ready_delay = 0; grant_q.delete();
    dm_at = -1; if_at = -1;
    if_req = 1'b1; if_addr = 32'h200;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
    for (cyc = 0; cyc < 60 && (dm_at < 0 || if_at < 0); cyc++) begin
      step();
      if (dm_valid) begin dm_at = cyc; dm_req = 1'b0; dm_we = 1'b0; end
      if (if_valid) begin if_at = cyc; if_req = 1'b0; end
    end
    n_checks++;
    if (dm_at < 0 || if_at < 0 || dm_at >= if_at) begin
      n_fail++; $display("FAIL prio_order: got dm_at=%0d if_at=%0d want data first", dm_at, if_at);
    end
    n_checks++;
    if (grant_q.size() != 2) begin
      n_fail++; $display("FAIL prio_grants: got %0d want 2", grant_q.size());
    end else begin
      n_checks++;
      if (grant_q[0].we !== 1'b1 || grant_q[0].addr !== 32'h200 || grant_q[0].wdata !== 32'hDEAD_BEEF) begin
        n_fail++; $display("FAIL prio_data_txn: got we=%b addr=%h wdata=%h want 1 00000200 deadbeef",
                           grant_q[0].we, grant_q[0].addr, grant_q[0].wdata);
      end
      n_checks++;
      if (grant_q[1].we !== 1'b0 || grant_q[1].addr !== 32'h200) begin
        n_fail++; $display("FAIL prio_fetch_txn: got we=%b addr=%h want 0 00000200", grant_q[1].we, grant_q[1].addr);
      end
    end
    n_checks++; if (if_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL prio_fetch_data: got %h want deadbeef", if_rdata); end
    step();
  endtask

  task automatic test_streak();
    int cyc;
    bit done;
    rand_delay = 1'b1; ready_delay = 0; grant_q.delete(); done = 1'b0;
    if_req = 1'b1; if_addr = 32'h700;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h600; dm_wdata = 32'h0;
    for (cyc = 0; cyc < 200 && !done; cyc++) begin
      step();
      if (dm_valid) dm_addr = dm_addr + 32'h4;
      if (if_valid) begin if_req = 1'b0; dm_req = 1'b0; done = 1'b1; end
    end
    rand_delay = 1'b0; ready_delay = 0;
    n_checks++; if (!done) begin n_fail++; $display("FAIL streak_timeout: got no if_valid want one within 200 cycles"); end
    n_checks++;
    if (grant_q.size() != MaxS + 1) begin
      n_fail++; $display("FAIL streak_grants: got %0d want %0d", grant_q.size(), MaxS + 1);
    end else begin
      for (int i = 0; i < MaxS; i++) begin
        n_checks++;
        if (grant_q[i].addr !== 32'h600 + 32'(4 * i)) begin
          n_fail++; $display("FAIL streak_data_%0d: got addr=%h want %h", i, grant_q[i].addr, 32'h600 + 32'(4 * i));
        end
      end
      n_checks++;
      if (grant_q[MaxS].addr !== 32'h700 || grant_q[MaxS].we !== 1'b0) begin
        n_fail++; $display("FAIL streak_fetch: got addr=%h we=%b want 00000700 0", grant_q[MaxS].addr, grant_q[MaxS].we);
      end
    end
    step();
    n_checks++; if (dut.u_streak.cnt_q !== '0) begin n_fail++; $display("FAIL streak_clear: got %0d want 0", dut.u_streak.cnt_q); end
  endtask

  task automatic test_flush();
    int lat, p0, d0;
    ready_delay = 0;
    if_req = 1'b1; if_addr = 32'h400;
    lat = 0;
    do begin step(); lat++; end while (!if_valid && lat < 20);
    if_req = 1'b0;
    step();
    n_checks++; if (if_rdata !== def_word(32'h400)) begin n_fail++; $display("FAIL flush_pre_rdata: got %h want %h", if_rdata, def_word(32'h400)); end
    p0 = if_pulses; d0 = done_cnt;
    ready_delay = 3; grant_q.delete();
    if_req = 1'b1; if_addr = 32'h500;
    step();
    step();
    if_flush = 1'b1; if_req = 1'b0;
    step();
    if_flush = 1'b0;
    lat = 0;
    while (mem_req && lat < 20) begin step(); lat++; end
    repeat (4) step();
    ready_delay = 0;
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL flush_completes: got %0d txns want 1", done_cnt - d0); end
    n_checks++; if (grant_q.size() != 1 || grant_q[0].addr !== 32'h500) begin n_fail++; $display("FAIL flush_grant: got %0d grants want 1 at 00000500", grant_q.size()); end
    n_checks++; if (if_pulses !== p0) begin n_fail++; $display("FAIL flush_no_valid: got %0d pulses want %0d", if_pulses, p0); end
    n_checks++; if (if_rdata !== def_word(32'h400)) begin n_fail++; $display("FAIL flush_rdata_kept: got %h want %h", if_rdata, def_word(32'h400)); end
  endtask

  task automatic test_reset_mid();
    int p_if, p_dm, d0;
    ready_delay = 20;
    p_if = if_pulses; p_dm = dm_pulses; d0 = done_cnt;
    if_req = 1'b1; if_addr = 32'h800;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h900; dm_wdata = $urandom;
    step();
    n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin n_fail++; $display("FAIL rstmid_data_first: got req=%b we=%b want 1 1", mem_req, mem_we); end
    n_checks++; if (dut.u_streak.cnt_q !== 1) begin n_fail++; $display("FAIL rstmid_streak_pre: got %0d want 1", dut.u_streak.cnt_q); end
    step();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== 66'd0) begin
      n_fail++; $display("FAIL rstmid_bus: got req=%b we=%b addr=%h wdata=%h want 0", mem_req, mem_we, mem_addr, mem_wdata);
    end
    n_checks++; if (dut.u_streak.cnt_q !== '0) begin n_fail++; $display("FAIL rstmid_streak: got %0d want 0", dut.u_streak.cnt_q); end
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    step();
    rst = 1'b0;
    repeat (25) step();
    ready_delay = 0;
    n_checks++;
    if (dm_pulses !== p_dm || if_pulses !== p_if) begin
      n_fail++; $display("FAIL rstmid_no_valid: got dm=%0d if=%0d pulses want %0d %0d", dm_pulses, if_pulses, p_dm, p_if);
    end
    n_checks++; if (done_cnt !== d0) begin n_fail++; $display("FAIL rstmid_abandon: got %0d txns want %0d", done_cnt, d0); end
  endtask

  task automatic test_ready_idle();
    int p_if, p_dm;
    logic [31:0] ird, drd;
    p_if = if_pulses; p_dm = dm_pulses; ird = if_rdata; drd = dm_rdata;
    inj_ready = 1'b1;
    step();
    inj_ready = 1'b0;
    step();
    step();
    n_checks++;
    if (if_pulses !== p_if || dm_pulses !== p_dm) begin
      n_fail++; $display("FAIL idle_ready_valid: got if=%0d dm=%0d want %0d %0d", if_pulses, dm_pulses, p_if, p_dm);
    end
    n_checks++; if (dut.state_q !== StIdle || mem_req !== 1'b0) begin n_fail++; $display("FAIL idle_ready_state: got state=%0d req=%b want idle 0", dut.state_q, mem_req); end
    n_checks++; if (if_rdata !== ird || dm_rdata !== drd) begin n_fail++; $display("FAIL idle_ready_rdata: got %h %h want %h %h", if_rdata, dm_rdata, ird, drd); end
  endtask

  // Random rounds: one optional fetch against a held burst of k data accesses.
  task automatic test_random();
    txn_t        ops[8];
    txn_t        exp_q[$];
    logic [31:0] exp_drd[8];
    logic [31:0] exp_frd, fa;
    int          k, nd_first, d_idx, cyc;
    bit          fon, f_done;
    rand_delay = 1'b1;
    for (int r = 0; r < 30; r++) begin
      fon = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 6);
      if (!fon && k == 0) k = 1;
      fa = 32'h2000 + 32'(4 * $urandom_range(0, 7));
      for (int i = 0; i < k; i++) begin
        ops[i].we = 1'($urandom_range(0, 1));
        ops[i].addr = 32'h2000 + 32'(4 * $urandom_range(0, 7));
        ops[i].wdata = $urandom;
      end
      // Data wins until the streak limit, then fetch, then the rest of the burst.
      exp_q.delete();
      nd_first = fon ? ((k < MaxS) ? k : MaxS) : k;
      for (int i = 0; i < k; i++) begin
        if (fon && i == nd_first) exp_q.push_back('{we: 1'b0, addr: fa, wdata: 32'h0});
        exp_q.push_back(ops[i]);
      end
      if (fon && nd_first == k) exp_q.push_back('{we: 1'b0, addr: fa, wdata: 32'h0});
      d_idx = 0;
      foreach (exp_q[i]) begin
        logic [31:0] rd;
        rd = ref_mem.exists(exp_q[i].addr) ? ref_mem[exp_q[i].addr] : def_word(exp_q[i].addr);
        if (fon && exp_q[i].wdata === 32'h0 && exp_q[i].addr === fa && !exp_q[i].we &&
            (i == nd_first)) begin
          exp_frd = rd;
        end else begin
          if (exp_q[i].we) begin ref_mem[exp_q[i].addr] = exp_q[i].wdata; rd = ~exp_q[i].wdata; end
          exp_drd[d_idx] = rd;
          d_idx++;
        end
      end
      grant_q.delete();
      d_idx = 0; f_done = 1'b0;
      if_req = fon; if_addr = fa;
      if (k > 0) begin
        dm_req = 1'b1; dm_we = ops[0].we; dm_addr = ops[0].addr; dm_wdata = ops[0].wdata;
      end
      for (cyc = 0; cyc < 300 && !(d_idx == k && (f_done || !fon)); cyc++) begin
        step();
        if (dm_valid) begin
          n_checks++;
          if (dm_rdata !== exp_drd[d_idx]) begin
            n_fail++; $display("FAIL rnd_dm_rdata r%0d op%0d: got %h want %h", r, d_idx, dm_rdata, exp_drd[d_idx]);
          end
          d_idx++;
          if (d_idx < k) begin
            dm_we = ops[d_idx].we; dm_addr = ops[d_idx].addr; dm_wdata = ops[d_idx].wdata;
          end else begin
            dm_req = 1'b0; dm_we = 1'b0;
          end
        end
        if (if_valid) begin
          n_checks++;
          if (if_rdata !== exp_frd) begin n_fail++; $display("FAIL rnd_if_rdata r%0d: got %h want %h", r, if_rdata, exp_frd); end
          if_req = 1'b0; f_done = 1'b1;
        end
      end
      n_checks++;
      if (cyc >= 300) begin n_fail++; $display("FAIL rnd_timeout r%0d: got %0d of %0d data done", r, d_idx, k); end
      n_checks++;
      if (grant_q.size() != exp_q.size()) begin
        n_fail++; $display("FAIL rnd_grant_count r%0d: got %0d want %0d", r, grant_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          n_checks++;
          if ({grant_q[i].we, grant_q[i].addr, grant_q[i].wdata} !== {exp_q[i].we, exp_q[i].addr, exp_q[i].wdata}) begin
            n_fail++; $display("FAIL rnd_grant r%0d #%0d: got we=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h",
                               r, i, grant_q[i].we, grant_q[i].addr, grant_q[i].wdata,
                               exp_q[i].we, exp_q[i].addr, exp_q[i].wdata);
          end
        end
      end
      if_req = 1'b0; dm_req = 1'b0;
      step();
      step();
    end
    rand_delay = 1'b0; ready_delay = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before 500000ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fetch_alone();
    test_min_latency();
    test_priority();
    test_streak();
    test_flush();
    test_reset_mid();
    test_ready_idle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-003 SHALL have parameter MAX_DATA_STREAK, default 4, consecutive data grants allowed while fetch waits.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports if_req input 1, if_addr input ADDR_WIDTH, for the fetch-stage read request.
REQ-007 SHALL have ports if_flush input 1, if_rdata output DATA_WIDTH, if_valid output 1, if_stall output 1.
REQ-008 SHALL have ports dm_req input 1, dm_we input 1, dm_addr input ADDR_WIDTH, dm_wdata input DATA_WIDTH, for the memory-stage access.
REQ-009 SHALL have ports dm_rdata output DATA_WIDTH, dm_valid output 1, dm_stall output 1.
REQ-010 SHALL have ports mem_req output 1, mem_we output 1, mem_addr output ADDR_WIDTH, mem_wdata output DATA_WIDTH, toward the single-ported memory.
REQ-011 SHALL have ports mem_ready input 1 (access complete this cycle), mem_rdata input DATA_WIDTH.

Function
REQ-012 SHALL implement FSM states IDLE, SERVE_FETCH, SERVE_DATA.
REQ-013 IDLE: dm_req only -> SERVE_DATA; if_req only -> SERVE_FETCH; neither -> stay.
REQ-014 IDLE with both requests: data wins unless streak counter == MAX_DATA_STREAK, then fetch wins.
REQ-015 Streak counter: +1 per data grant issued while if_req high; cleared on any fetch grant or when if_req low in IDLE; saturates at MAX_DATA_STREAK.
REQ-016 On grant, address/we/wdata of winner SHALL be registered into mem_addr/mem_we/mem_wdata; mem_req high from the next cycle until mem_ready is sampled high.
REQ-017 mem_we SHALL be 0 for every fetch transaction; mem_addr/mem_we/mem_wdata stable while mem_req high.
REQ-018 On mem_ready in SERVE_x: capture mem_rdata into x_rdata, pulse x_valid for exactly one cycle, return to IDLE.
REQ-019 x_rdata SHALL hold its last captured value until the next completion for that requester.
REQ-020 Minimum latency: request seen in IDLE at cycle N, mem_req at N+1, mem_ready at N+1 gives x_valid at N+2.
REQ-021 if_stall = if_req & ~if_valid; dm_stall = dm_req & ~dm_valid; both combinational.
REQ-022 Requesters hold req and operands stable until valid; arbiter is not required to check.
REQ-023 if_flush high during SERVE_FETCH (any cycle through completion) SHALL let the memory access finish but suppress if_valid and leave if_rdata unchanged.
REQ-024 if_flush high in IDLE SHALL mask if_req for arbitration that cycle.
REQ-025 mem_ready while IDLE SHALL be ignored.
REQ-026 A new request arriving while serving SHALL wait; no preemption.

Reset
REQ-027 rst high SHALL immediately force: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, if_valid 0, dm_valid 0, if_rdata 0, dm_rdata 0, streak 0.
REQ-028 Reset mid-transaction SHALL abandon it; no valid pulse follows reset release.
REQ-029 First grant possible in the first rising edge after rst deasserts.

Structure
REQ-030 State enum type and default ADDR_WIDTH/DATA_WIDTH constants SHALL live in shared package rvscc_pkg.
REQ-031 Streak counter and its saturation/clear logic SHALL be sub-module arb_streak_counter.
REQ-032 Stall outputs SHALL be connected to the pipeline hazard logic as additional fetch/decode stall sources.

Verification
REQ-033 Fetch alone, if_addr=0x100, mem_ready one cycle after mem_req -> mem_addr=0x100, mem_we=0, if_valid pulse with if_rdata=mem_rdata.
REQ-034 Simultaneous if_req and dm_req (dm_we=1, dm_addr=0x200, dm_wdata=0xDEADBEEF) -> data served first with mem_we=1, then fetch.
REQ-035 dm_req held continuously with if_req high, MAX_DATA_STREAK=4 -> exactly 4 data grants then one fetch grant.
REQ-036 if_flush pulsed during SERVE_FETCH with mem_ready delayed 3 cycles -> mem transaction completes, no if_valid, if_rdata unchanged.
REQ-037 rst asserted while mem_req high in SERVE_DATA -> mem_req 0 same cycle, no dm_valid after release, streak 0.
REQ-038 mem_ready pulsed in IDLE with no requests -> no valid pulse, state stays IDLE.
